mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port to one-port memory arbiter sharing the single-port RAM_32x4096_delay1 between the MIPS CPU instruction-fetch port and its load/store data port.
- Translates 32-bit byte addresses to 12-bit RAM word indices and sequences requests to respect the RAM's one-cycle read latency.
- Returns read data and a per-port done strobe.
- Sits between the CPU core and the RAM in the top-level and the CPU testbench.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address mapped to RAM word 0.
- RAM_ADDR_W, 12: RAM word-address width (4096 words, 16 KiB window).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_address  input  32  instruction byte address.
- instr_read  input  1  instruction read request; held until instr_done.
- instr_readdata  output  32  instruction word; valid when instr_done=1.
- instr_done  output  1  one-cycle completion strobe, instruction port.
- data_address  input  32  data byte address.
- data_read  input  1  data read request; held until data_done.
- data_write  input  1  data write request; held until data_done.
- data_writedata  input  32  store word.
- data_readdata  output  32  load word; valid when data_done=1.
- data_done  output  1  one-cycle completion strobe, data port.
- address  output  RAM_ADDR_W  RAM word address.
- write  output  1  RAM write enable.
- read  output  1  RAM read enable.
- writedata  output  32  RAM write data.
- readdata  input  32  RAM read data; valid the cycle after read.
- err  output  1  see Optional Feature; tied 0 when the feature is absent.

Behaviour:
- Reset: state=IDLE, last_grant=INSTR. All outputs are 0: read, write, address, writedata, both done, both readdata, err.
- Word index = (port_address - BASE_ADDR)[RAM_ADDR_W+1:2]. Bits [1:0] are ignored. Higher bits are ignored when the feature is absent.
- Data port with data_read and data_write both set: treated as a write.
- States:
  - IDLE (no access in flight).
  - RESP (access issued last cycle; response this cycle).
- Issue cycle N (IDLE, or RESP with an eligible requester):
  - Choose one requester and drive address/read/write/writedata combinationally from it.
  - Record the granted port, request type and grant.
  - Next state is RESP.
- Response cycle N+1 (RESP):
  - Assert <port>_done=1 for the recorded port.
  - For reads, <port>_readdata = RAM readdata (pass-through).
  - For writes, readdata is 0.
- Latency: done is asserted exactly one cycle after issue, for reads and writes alike.
- Done strobe: one cycle only. The requester drops or changes its request on the edge ending the done cycle.
- Eligibility in RESP: the port being completed is masked and cannot be re-granted in that cycle.
  - Another requester may be issued in that cycle, giving back-to-back throughput of 1 access/cycle when the ports alternate.
  - A single port alone gets 1 access per 2 cycles.
  - If nothing is eligible, next state is IDLE.
- Arbitration:
  - One eligible requester: it is granted.
  - Both eligible: grant the port not equal to last_grant (round-robin).
  - last_grant updates on every grant.
  - First tie after reset goes to DATA.
- Idle RAM outputs: read=write=0, address and writedata hold 0.
- Reset mid-operation: the in-flight response is dropped (no done), state returns to IDLE, a new arbitration starts the cycle after rst deasserts.

Optional Feature:
Macro MEM_ARBITER_RANGE_CHECK_EN.
- Defined:
  - A request is illegal if port_address[1:0] != 0 or (port_address - BASE_ADDR) >= 4*2^RAM_ADDR_W (unsigned).
  - An illegal request still wins arbitration normally but drives no RAM read/write.
  - Its response cycle asserts done with readdata=0 and err=1 (err is a one-cycle strobe aligned to done).
- Undefined: no check; err is constant 0; addresses wrap modulo the window.

Decomposition:
- Package mem_arbiter_pkg:
  - typedef enum state_t {IDLE, RESP}.
  - typedef enum port_t {PORT_INSTR, PORT_DATA}.
  - Constants RAM_WORDS=4096 and WINDOW_BYTES=16384.
- One sub-module: mem_arbiter_rr_pick, a 2-way round-robin picker (inputs req[1:0], mask[1:0], last_grant; outputs grant_valid, grant_port).

Test Plan:
- Reset then instr_read @0x0000_0010, RAM word 4 = 0x2409_0005 -> cycle N: address=4, read=1; N+1: instr_done=1, instr_readdata=0x2409_0005.
- data_write @0x0000_0400 data 0xDEAD_BEEF, then data_read same address -> write=1/address=256 at issue; data_done next cycle; read returns 0xDEAD_BEEF two cycles later.
- Both ports request from the first cycle after reset -> DATA granted first, INSTR issued in DATA's response cycle; instr_done one cycle after data_done; no idle gap.
- Continuous contention for 8 accesses -> grants strictly alternate DATA, INSTR, ...; done strobes never overlap.
- rst pulsed in the RESP cycle of an instr read -> no instr_done; all outputs 0; the held request is re-issued the first cycle after rst falls.
- With MEM_ARBITER_RANGE_CHECK_EN: data_read @0x0000_4000 and @0x0000_0002 -> read=0, data_done=1, err=1, data_readdata=0; without the macro, 0x4000 reads word 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port to one-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  typedef enum logic {PORT_INSTR = 1'b0, PORT_DATA = 1'b1} port_t;

  localparam int RAM_WORDS    = 4096;
  localparam int WINDOW_BYTES = 16384;

  // Request is illegal when misaligned or outside the RAM window (unsigned compare).
  function automatic logic addr_illegal(input logic [31:0] addr,
                                        input logic [31:0] off,
                                        input int          aw);
    return (addr[1:0] != 2'b00) || ({1'b0, off} >= (33'd4 << aw));
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// 2-way round-robin picker: grants the single eligible requester, or on a tie
// the port that did not win last time.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  port_t      i_last_grant,
  output logic       o_grant_valid,
  output port_t      o_grant_port
);

  logic [1:0] w_elig;

  // Eligible = requesting and not masked; tie resolved against last grant.
  always_comb begin
    w_elig        = i_req & ~i_mask;
    o_grant_valid = |w_elig;
    o_grant_port  = PORT_INSTR;
    if (&w_elig)
      o_grant_port = (i_last_grant == PORT_DATA) ? PORT_INSTR : PORT_DATA;
    else if (w_elig[1])
      o_grant_port = PORT_DATA;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port RAM (1-cycle read latency) between the CPU instruction
// fetch port and the load/store port. Issue in cycle N, done strobe in N+1.
// Optional: define MEM_ARBITER_RANGE_CHECK_EN to flag misaligned or
// out-of-window requests with err (no RAM access, readdata 0).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RAM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_address,
  input  logic                  instr_read,
  output logic [31:0]           instr_readdata,
  output logic                  instr_done,
  input  logic [31:0]           data_address,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [31:0]           data_writedata,
  output logic [31:0]           data_readdata,
  output logic                  data_done,
  output logic [RAM_ADDR_W-1:0] address,
  output logic                  write,
  output logic                  read,
  output logic [31:0]           writedata,
  input  logic [31:0]           readdata,
  output logic                  err
);

  state_t      r_state, w_next;
  port_t       r_last_grant, r_port;
  logic        r_wr, r_bad;

  logic [1:0]  w_req, w_mask;
  logic        w_gv, w_issue, w_is_wr, w_bad;
  port_t       w_gp;
  logic [31:0] w_sel_addr, w_off;

  assign w_req  = {data_read | data_write, instr_read};
  // The port being completed this cycle cannot be re-granted.
  assign w_mask = (r_state == RESP) ? ((r_port == PORT_DATA) ? 2'b10 : 2'b01) : 2'b00;

  mem_arbiter_rr_pick u_pick (
    .i_req         (w_req),
    .i_mask        (w_mask),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_gv),
    .o_grant_port  (w_gp)
  );

  assign w_issue    = w_gv & ~rst;
  assign w_sel_addr = (w_gp == PORT_DATA) ? data_address : instr_address;
  assign w_off      = w_sel_addr - BASE_ADDR;
  // Read+write together on the data port is a write.
  assign w_is_wr    = (w_gp == PORT_DATA) & data_write;

`ifdef MEM_ARBITER_RANGE_CHECK_EN
  assign w_bad = addr_illegal(w_sel_addr, w_off, RAM_ADDR_W);
`else
  logic w_unused_off;
  assign w_unused_off = ^{w_off[31:RAM_ADDR_W+2], w_off[1:0]};
  assign w_bad        = 1'b0;
`endif

  // State register plus record of the granted access for its response cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_INSTR;
      r_port       <= PORT_INSTR;
      r_wr         <= 1'b0;
      r_bad        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_last_grant <= w_gp;
        r_port       <= w_gp;
        r_wr         <= w_is_wr;
        r_bad        <= w_bad;
      end
    end
  end

  // Next state, RAM drive for the issued access, and response for the recorded one.
  always_comb begin
    w_next         = IDLE;
    address        = '0;
    read           = 1'b0;
    write          = 1'b0;
    writedata      = '0;
    instr_done     = 1'b0;
    data_done      = 1'b0;
    instr_readdata = '0;
    data_readdata  = '0;
    err            = 1'b0;
    if (w_issue) begin
      w_next    = RESP;
      address   = w_off[RAM_ADDR_W+1:2];
      read      = ~w_is_wr & ~w_bad;
      write     = w_is_wr & ~w_bad;
      writedata = w_is_wr ? data_writedata : '0;
    end
    if ((r_state == RESP) && !rst) begin
      err = r_bad;
      if (r_port == PORT_DATA) begin
        data_done     = 1'b1;
        data_readdata = (r_wr || r_bad) ? '0 : readdata;
      end else begin
        instr_done     = 1'b1;
        instr_readdata = (r_wr || r_bad) ? '0 : readdata;
      end
    end
  end

endmodule
